regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DSIZE, default 16, data width in bits.
REQ-002 SHALL have parameter ASIZE, default 3, register address width; NREG = 2**ASIZE registers.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 SHALL have parameter R1_INIT, default 5, reset value of register 1.
REQ-005 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports wen0/wen1  input  1 each  write enables, ports 0/1.
REQ-008 SHALL have ports waddr0/waddr1  input  ASIZE each  write addresses.
REQ-009 SHALL have ports wdata0/wdata1  input  DSIZE each  write data.
REQ-010 SHALL have ports raddr1/raddr2  input  ASIZE each  read addresses.
REQ-011 SHALL have ports rdata1/rdata2  output  DSIZE each  read data, combinational.
REQ-012 SHALL have port iss_en  input  1  issue strobe: mark a register pending.
REQ-013 SHALL have port iss_addr  input  ASIZE  register marked pending by iss_en.
REQ-014 SHALL have ports rbusy1/rbusy2  output  1 each  pending flag of raddr1/raddr2.
REQ-015 SHALL have port stall  output  1  rbusy1 OR rbusy2.

Function
REQ-016 SHALL hold NREG DSIZE-bit registers plus an NREG-bit pending (busy) vector.
REQ-017 SHALL hardwire register 0: reads return 0, writes ignored, busy bit never set.
REQ-018 SHALL write wdata0 to waddr0 on a clock edge when wen0=1 and waddr0!=0; likewise port 1.
REQ-019 SHALL, when both ports write the same nonzero address in one cycle, store wdata1 (port 1 wins).
REQ-020 SHALL, with BYPASS=0, return registered contents only (new value visible the cycle after the write edge).
REQ-021 SHALL, with BYPASS=1, return in the same cycle the data being written to raddrN (port 1 over port 0 on collision), except address 0.
REQ-022 SHALL set busy[iss_addr] on a clock edge when iss_en=1 and iss_addr!=0.
REQ-023 SHALL clear busy[a] on a clock edge when any enabled write targets a (a!=0).
REQ-024 SHALL, when issue and write target the same register in one cycle, leave busy set (issue wins, new producer).
REQ-025 SHALL drive rbusyN from the registered busy bit; with BYPASS=1, a same-cycle write to raddrN forces rbusyN=0 unless iss_en targets it too.
REQ-026 SHALL treat an iss_en to an already-busy register as a no-op (stays busy); a write to a non-busy register SHALL leave it clear.
REQ-027 SHALL produce no X on outputs for any in-range address; all addresses are in range by construction.

Reset
REQ-028 SHALL, while rst=1, asynchronously force all registers to 0 except register 1 = R1_INIT[DSIZE-1:0].
REQ-029 SHALL, while rst=1, clear the entire busy vector, ignoring writes and issues.
REQ-030 SHALL, during reset, drive rdataN from reset contents (no bypass), rbusy1=rbusy2=stall=0.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Verification
REQ-032 SHALL cover reset: assert rst mid-cycle with no clock -> rdata1 at raddr1=1 reads 5, raddr2=2 reads 0, stall=0 immediately.
REQ-033 SHALL cover dual write collision: wen0=wen1=1, waddr0=waddr1=3, wdata0=0x1111, wdata1=0x2222 -> next cycle r3=0x2222; BYPASS=1 -> rdata1 (raddr1=3) = 0x2222 in the same cycle.
REQ-034 SHALL cover r0: wen0=1, waddr0=0, wdata0=0xFFFF, iss_en=1, iss_addr=0 -> rdata(0)=0, rbusy=0 always.
REQ-035 SHALL cover scoreboard: iss_en to r4 -> next cycle raddr1=4 gives rbusy1=1, stall=1; wen1 to r4 with 0x00AB -> BYPASS=1 same cycle rbusy1=0, rdata1=0x00AB; next cycle busy cleared.
REQ-036 SHALL cover issue/write race: same cycle iss_en to r5 and wen0 to r5 -> r5 updated, busy[5]=1 next cycle.
REQ-037 SHALL cover BYPASS=0 build: write r2=0x0042 -> rdata(2) still old value that cycle, 0x0042 the next.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-write / two-read register file with a per-register pending (busy) scoreboard.
// Register 0 reads as zero. Optional same-cycle write-to-read forwarding on both read ports.
module regfile_sb #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 3,
  parameter int BYPASS  = 1,
  parameter int R1_INIT = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen0,
  input  logic             wen1,
  input  logic [ASIZE-1:0] waddr0,
  input  logic [ASIZE-1:0] waddr1,
  input  logic [DSIZE-1:0] wdata0,
  input  logic [DSIZE-1:0] wdata1,
  input  logic [ASIZE-1:0] raddr1,
  input  logic [ASIZE-1:0] raddr2,
  output logic [DSIZE-1:0] rdata1,
  output logic [DSIZE-1:0] rdata2,
  input  logic             iss_en,
  input  logic [ASIZE-1:0] iss_addr,
  output logic             rbusy1,
  output logic             rbusy2,
  output logic             stall
);

  localparam int NREG = 2 ** ASIZE;
  localparam logic [DSIZE-1:0] R1_RST = DSIZE'(R1_INIT);

  logic [NREG-1:0][DSIZE-1:0] regs_reg;
  logic [NREG-1:0][DSIZE-1:0] regs_next;
  logic [NREG-1:0]            busy_reg;
  logic [NREG-1:0]            busy_next;
  logic [NREG-1:0]            wr0_hit;
  logic [NREG-1:0]            wr1_hit;
  logic [NREG-1:0]            iss_hit;

  // Per-register write/issue decode; register 0 never decodes a hit.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign wr0_hit[gi]   = 1'b0;
      assign wr1_hit[gi]   = 1'b0;
      assign iss_hit[gi]   = 1'b0;
      assign regs_next[gi] = '0;
      assign busy_next[gi] = 1'b0;
    end else begin : g_nz
      assign wr0_hit[gi]   = wen0 && (waddr0 == ASIZE'(gi));
      assign wr1_hit[gi]   = wen1 && (waddr1 == ASIZE'(gi));
      assign iss_hit[gi]   = iss_en && (iss_addr == ASIZE'(gi));
      assign regs_next[gi] = wr1_hit[gi] ? wdata1 : wdata0;
      // Issue beats a completing write: the new producer keeps the register pending.
      assign busy_next[gi] = iss_hit[gi] ? 1'b1
                           : ((wr0_hit[gi] || wr1_hit[gi]) ? 1'b0 : busy_reg[gi]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= (i == 1) ? R1_RST : '0;
      end
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr0_hit[i] || wr1_hit[i]) begin
          regs_reg[i] <= regs_next[i];
        end
      end
      busy_reg <= busy_next;
    end
  end

  logic [1:0][ASIZE-1:0] raddr_v;
  assign raddr_v = {raddr2, raddr1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DSIZE-1:0] rd;
    logic             rb;
    logic             hit0;
    logic             hit1;
    logic             hit_iss;
    logic             nz;

    assign nz      = (raddr_v[gi] != '0);
    assign hit0    = wen0 && (waddr0 == raddr_v[gi]);
    assign hit1    = wen1 && (waddr1 == raddr_v[gi]);
    assign hit_iss = iss_en && (iss_addr == raddr_v[gi]);

    // Forwarding is suppressed during reset so reads reflect reset contents.
    always_comb begin
      rd = regs_reg[raddr_v[gi]];
      rb = busy_reg[raddr_v[gi]];
      if ((BYPASS != 0) && !rst && nz) begin
        if (hit1) begin
          rd = wdata1;
        end else if (hit0) begin
          rd = wdata0;
        end
        if ((hit0 || hit1) && !hit_iss) begin
          rb = 1'b0;
        end
      end
      if (rst) begin
        rb = 1'b0;
      end
    end
  end

  assign rdata1 = g_rd[0].rd;
  assign rdata2 = g_rd[1].rd;
  assign rbusy1 = g_rd[0].rb;
  assign rbusy2 = g_rd[1].rb;
  assign stall  = rbusy1 | rbusy2;

endmodule
